alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 19 +
 rtl/rr_arb2.sv | 30 +++
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arbiter_pkg;

  localparam int unsigned DefaultDataW = 16;

  // ALU_FUN[3:2] selects the execution unit inside the shared ALU.
  localparam logic [1:0] AluGrpArith = 2'b00;
  localparam logic [1:0] AluGrpLogic = 2'b01;
  localparam logic [1:0] AluGrpCmp   = 2'b10;
  localparam logic [1:0] AluGrpShift = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer moves to the loser whenever a grant is taken.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_vld_o = |req_i;
    gnt_idx_o = req_i[ptr_q] ? ptr_q : ~ptr_q;
    ptr_d     = ptr_q;
    if (take_i && gnt_vld_o) begin
      ptr_d = ~gnt_idx_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared ALU, one operation outstanding at a time,
// with a bounded wait for the ALU result.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W  = DefaultDataW,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [1:0]          REQ_VALID,
  output logic [1:0]          REQ_READY,
  input  logic [2*DATA_W-1:0] REQ_A,
  input  logic [2*DATA_W-1:0] REQ_B,
  input  logic [7:0]          REQ_FUN,
  output logic [1:0]          RSP_VALID,
  input  logic [1:0]          RSP_READY,
  output logic [DATA_W-1:0]   RSP_DATA,
  output logic                RSP_ERR,
  output logic [DATA_W-1:0]   ALU_A,
  output logic [DATA_W-1:0]   ALU_B,
  output logic [3:0]          ALU_FUN,
  output logic                ALU_EN,
  input  logic [DATA_W-1:0]   ALU_OUT,
  input  logic                ALU_OUT_VALID
);

  localparam logic [7:0] TimeoutC = 8'(TIMEOUT);

  state_e              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [1:0]          req_ready_q, req_ready_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                alu_en_q, alu_en_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [3:0]          alu_fun_q, alu_fun_d;

  logic arb_take;
  logic arb_vld;
  logic arb_idx;

  rr_arb2 u_rr_arb2 (
    .clk_i     (CLK),
    .rst_i     (RST),
    .req_i     (REQ_VALID),
    .take_i    (arb_take),
    .gnt_vld_o (arb_vld),
    .gnt_idx_o (arb_idx)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    req_ready_d = 2'b00;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    alu_en_d    = 1'b0;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fun_d   = alu_fun_q;
    arb_take    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arb_vld) begin
          arb_take    = 1'b1;
          gnt_d       = arb_idx;
          req_ready_d = arb_idx ? 2'b10 : 2'b01;
          alu_a_d     = arb_idx ? REQ_A[DATA_W +: DATA_W] : REQ_A[0 +: DATA_W];
          alu_b_d     = arb_idx ? REQ_B[DATA_W +: DATA_W] : REQ_B[0 +: DATA_W];
          alu_fun_d   = arb_idx ? REQ_FUN[7:4] : REQ_FUN[3:0];
          state_d     = StIssue;
        end
      end
      StIssue: begin
        alu_en_d = 1'b1;
        cnt_d    = 8'd0;
        state_d  = StWait;
      end
      StWait: begin
        // A result arriving on the timeout cycle still wins over the error.
        if (ALU_OUT_VALID) begin
          rsp_data_d  = ALU_OUT;
          rsp_err_d   = 1'b0;
          rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
          state_d     = StResp;
        end else if (cnt_q + 8'd1 == TimeoutC) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: begin
        if (RSP_READY[gnt_q]) begin
          rsp_valid_d = 2'b00;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      gnt_q       <= 1'b0;
      cnt_q       <= 8'd0;
      req_ready_q <= 2'b00;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      alu_en_q    <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      alu_en_q    <= alu_en_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fun_q   <= alu_fun_d;
    end
  end

  assign REQ_READY = req_ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_ERR   = rsp_err_q;
  assign ALU_EN    = alu_en_q;
  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_FUN   = alu_fun_q;

endmodule
